// File: rtl/pool_pkg.sv
`default_nettype none
// ============================================================================
// Module      : pool_pkg
// Description : Shared defaults and helpers for the 2x2 pooling engine.
//               Holds the default element width, channel parallelism and
//               counter width, plus the bit-offset helper that locates one
//               element inside the packed feature block.
// Revision    : 1.0  initial release
// ============================================================================
package pool_pkg;

  localparam int POOL_DATA_W = 16;
  localparam int POOL_PAR_CH = 4;
  localparam int POOL_CNT_W  = 8;

  // LSB position of element (lane, row, col) in the packed 2x2 feature block.
  // Each lane owns four consecutive elements, ordered row-major.
  function automatic int lane_lsb(input int data_w, input int lane,
                                  input int row, input int col);
    return data_w * (lane * 4 + row * 2 + col);
  endfunction

endpackage
`default_nettype wire

// File: rtl/pool_reduce4.sv
`default_nettype none
// ============================================================================
// Module      : pool_reduce4
// Description : Combinational reduction of one 2x2 window (four signed
//               elements) to a single pooled value.
//               Macro POOL_AVG_EN: defined   -> average pooling
//                                  undefined -> max pooling (default)
// Ports       : blk_i  four packed signed elements, element i at
//                      [DATA_W*i +: DATA_W] (i = row*2 + col)
//               res_o  pooled result
// Revision    : 1.0  initial release
// ============================================================================
module pool_reduce4
  import pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W
) (
  input  logic [4*DATA_W-1:0] blk_i,
  output logic [DATA_W-1:0]   res_o
);

  logic signed [DATA_W-1:0] w_e [4];

  for (genvar i = 0; i < 4; i++) begin : g_elem
    assign w_e[i] = blk_i[lane_lsb(DATA_W, 0, i / 2, i % 2) +: DATA_W];
  end

`ifdef POOL_AVG_EN
  // Two guard bits keep the four-way sum exact; dropping the two LSBs is the
  // arithmetic shift by 2, and keeping DATA_W bits above them is the truncation.
  logic signed [DATA_W+1:0] w_sum;

  assign w_sum = {{2{w_e[0][DATA_W-1]}}, w_e[0]}
               + {{2{w_e[1][DATA_W-1]}}, w_e[1]}
               + {{2{w_e[2][DATA_W-1]}}, w_e[2]}
               + {{2{w_e[3][DATA_W-1]}}, w_e[3]};
  assign res_o = w_sum[DATA_W+1:2];
`else
  logic signed [DATA_W-1:0] w_max01;
  logic signed [DATA_W-1:0] w_max23;

  assign w_max01 = (w_e[0] > w_e[1]) ? w_e[0] : w_e[1];
  assign w_max23 = (w_e[2] > w_e[3]) ? w_e[2] : w_e[3];
  assign res_o   = (w_max01 > w_max23) ? w_max01 : w_max23;
`endif

endmodule
`default_nettype wire

// File: rtl/pool2x2_engine.sv
`default_nettype none
// ============================================================================
// Module      : pool2x2_engine
// Description : 2x2 / stride-2 pooling engine over an in_size x in_size map,
//               PAR_CH channels per cycle. Registered window/channel
//               addresses drive an external buffer which returns the 2x2 block
//               combinationally; one pooled value per lane is registered on
//               every enabled edge.
//               Macro POOL_AVG_EN selects average pooling (default: max).
// Ports       : clk, rst         clock, asynchronous active-high reset
//               en               advance enable (low = hold everything)
//               in_size          map height/width
//               channel_num      total channel count
//               infeature_block  2x2 block per lane from the buffer
//               outfeature       pooled result per lane
//               inh, inw         top-left corner of the current window
//               channel_sel      base channel of the current group
//               channel_done     pulse with the last output of a group
//               done             sticky completion flag
//               out_valid        outfeature updated on this edge
// Revision    : 1.0  initial release
// ============================================================================
module pool2x2_engine
  import pool_pkg::*;
#(
  parameter int DATA_W = POOL_DATA_W,
  parameter int PAR_CH = POOL_PAR_CH,
  parameter int CNT_W  = POOL_CNT_W
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic [CNT_W-1:0]         in_size,
  input  logic [CNT_W-1:0]         channel_num,
  input  logic [PAR_CH*4*DATA_W-1:0] infeature_block,
  output logic [PAR_CH*DATA_W-1:0] outfeature,
  output logic [CNT_W-1:0]         inh,
  output logic [CNT_W-1:0]         inw,
  output logic [CNT_W-1:0]         channel_sel,
  output logic                     channel_done,
  output logic                     done,
  output logic                     out_valid
);

  logic [CNT_W-1:0]         inh_q, inh_d;
  logic [CNT_W-1:0]         inw_q, inw_d;
  logic [CNT_W-1:0]         sel_q, sel_d;
  logic [PAR_CH*DATA_W-1:0] out_q, out_d;
  logic                     valid_q, valid_d;
  logic                     cdone_q, cdone_d;
  logic                     done_q, done_d;

  logic [PAR_CH*DATA_W-1:0] w_res;
  logic [CNT_W:0]           w_inw_far;
  logic [CNT_W:0]           w_inh_far;
  logic [CNT_W:0]           w_sel_far;
  logic                     w_end_row;
  logic                     w_end_map;
  logic                     w_last_grp;
  logic                     w_degen;

  for (genvar c = 0; c < PAR_CH; c++) begin : g_lane
    pool_reduce4 #(
      .DATA_W (DATA_W)
    ) u_reduce (
      .blk_i (infeature_block[lane_lsb(DATA_W, c, 0, 0) +: 4*DATA_W]),
      .res_o (w_res[c*DATA_W +: DATA_W])
    );
  end

  // "pos + 2 > in_size - 2" is evaluated as "pos + 4 > in_size" one bit wider,
  // so it cannot underflow and handles odd sizes by flooring.
  assign w_inw_far  = {1'b0, inw_q} + (CNT_W+1)'(4);
  assign w_inh_far  = {1'b0, inh_q} + (CNT_W+1)'(4);
  assign w_sel_far  = {1'b0, sel_q} + (CNT_W+1)'(PAR_CH);
  assign w_end_row  = w_inw_far > {1'b0, in_size};
  assign w_end_map  = w_inh_far > {1'b0, in_size};
  assign w_last_grp = w_sel_far >= {1'b0, channel_num};
  // No window exists at all: finish without producing output.
  assign w_degen    = (in_size < CNT_W'(2)) || (channel_num == '0);

  always_comb begin
    inh_d   = inh_q;
    inw_d   = inw_q;
    sel_d   = sel_q;
    out_d   = out_q;
    valid_d = 1'b0;
    cdone_d = 1'b0;
    done_d  = done_q;
    if (en && !done_q) begin
      if (w_degen) begin
        done_d = 1'b1;
      end else begin
        out_d   = w_res;
        valid_d = 1'b1;
        if (!w_end_row) begin
          inw_d = inw_q + CNT_W'(2);
        end else begin
          inw_d = '0;
          if (!w_end_map) begin
            inh_d = inh_q + CNT_W'(2);
          end else begin
            inh_d   = '0;
            cdone_d = 1'b1;
            // The final group leaves channel_sel on its base channel.
            if (w_last_grp) begin
              done_d = 1'b1;
            end else begin
              sel_d = sel_q + CNT_W'(PAR_CH);
            end
          end
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      inh_q   <= '0;
      inw_q   <= '0;
      sel_q   <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
      cdone_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      inh_q   <= inh_d;
      inw_q   <= inw_d;
      sel_q   <= sel_d;
      out_q   <= out_d;
      valid_q <= valid_d;
      cdone_q <= cdone_d;
      done_q  <= done_d;
    end
  end

  assign outfeature   = out_q;
  assign inh          = inh_q;
  assign inw          = inw_q;
  assign channel_sel  = sel_q;
  assign channel_done = cdone_q;
  assign done         = done_q;
  assign out_valid    = valid_q;

endmodule
`default_nettype wire

// File: tb/tb_pool2x2_engine.sv
`default_nettype none
// ============================================================================
// Module      : tb_pool2x2_engine
// Description : Self-checking bench for pool2x2_engine. A feature-map array
//               plays the external buffer; expected windows, flags and pooled
//               values come from a window list built from the map geometry.
//               Macro POOL_AVG_EN selects the average-pooling expectation.
// Revision    : 1.0  initial release
// ============================================================================
module tb_pool2x2_engine;

  localparam int DW = 16;
  localparam int PC = 4;
  localparam int CW = 8;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              en  = 1'b0;
  logic [CW-1:0]     in_size = '0;
  logic [CW-1:0]     channel_num = '0;
  logic [PC*4*DW-1:0] infeature_block = '0;
  logic [PC*DW-1:0]  outfeature;
  logic [CW-1:0]     inh;
  logic [CW-1:0]     inw;
  logic [CW-1:0]     channel_sel;
  logic              channel_done;
  logic              done;
  logic              out_valid;

  int n_checks = 0;
  int n_errors = 0;

  logic signed [DW-1:0] fm [16][16][16];
  longint exp_last [PC];
  bit     exp_ok   [PC];

  typedef struct {
    int base;
    int h;
    int w;
    bit glast;
    bit last;
  } win_t;
  win_t wq[$];

  pool2x2_engine #(
    .DATA_W (DW),
    .PAR_CH (PC),
    .CNT_W  (CW)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .en              (en),
    .in_size         (in_size),
    .channel_num     (channel_num),
    .infeature_block (infeature_block),
    .outfeature      (outfeature),
    .inh             (inh),
    .inw             (inw),
    .channel_sel     (channel_sel),
    .channel_done    (channel_done),
    .done            (done),
    .out_valid       (out_valid)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input longint obs, input longint exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  function automatic longint lane_out(input int c);
    logic signed [DW-1:0] v;
    v = outfeature[c*DW +: DW];
    return longint'(v);
  endfunction

  function automatic longint fm_get(input int ch, input int r, input int c);
    if (ch < 16 && r < 16 && c < 16) return longint'(fm[ch][r][c]);
    return 0;
  endfunction

  function automatic longint ref_pool(input int ch, input int r, input int c);
    longint v [4];
    longint m;
    v[0] = fm_get(ch, r, c);
    v[1] = fm_get(ch, r, c + 1);
    v[2] = fm_get(ch, r + 1, c);
    v[3] = fm_get(ch, r + 1, c + 1);
`ifdef POOL_AVG_EN
    m = (v[0] + v[1] + v[2] + v[3]) >>> 2;
`else
    m = v[0];
    for (int i = 1; i < 4; i++) if (v[i] > m) m = v[i];
`endif
    return m;
  endfunction

  // Buffer model: returns the 2x2 block at whatever address the DUT presents.
  task automatic drive_block();
    for (int c = 0; c < PC; c++)
      for (int r = 0; r < 2; r++)
        for (int k = 0; k < 2; k++)
          infeature_block[DW*(c*4 + r*2 + k) +: DW] =
            DW'(fm_get(int'(channel_sel) + c, int'(inh) + r, int'(inw) + k));
  endtask

  task automatic fill(input int mode);
    for (int ch = 0; ch < 16; ch++)
      for (int r = 0; r < 16; r++)
        for (int c = 0; c < 16; c++)
          fm[ch][r][c] = (mode == 0) ? DW'((r % 3) + 1) : DW'($urandom);
  endtask

  task automatic check_zero_state(input string tag);
    check_eq({tag, " inh"}, inh, 0);
    check_eq({tag, " inw"}, inw, 0);
    check_eq({tag, " sel"}, channel_sel, 0);
    check_eq({tag, " outfeature"}, outfeature, 0);
    check_eq({tag, " out_valid"}, out_valid, 0);
    check_eq({tag, " channel_done"}, channel_done, 0);
    check_eq({tag, " done"}, done, 0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    en  = 1'b0;
    #1;
    check_zero_state("reset");
    repeat (2) @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < PC; c++) begin
      exp_last[c] = 0;
      exp_ok[c]   = 1'b1;
    end
  endtask

  task automatic check_hold(input string tag);
    for (int c = 0; c < PC; c++)
      if (exp_ok[c]) check_eq({tag, " hold lane"}, lane_out(c), exp_last[c]);
  endtask

  // enmode: 0 = always enabled, 1 = toggle every cycle, 2 = random
  task automatic run_case(input string name, input int s, input int n, input int enmode);
    int wpr, groups, total, idx, cyc, edges, exp_sel;
    longint e;
    do_reset();
    in_size     = CW'(s);
    channel_num = CW'(n);
    wq.delete();
    wpr    = s / 2;
    groups = (n + PC - 1) / PC;
    if (s >= 2 && n > 0)
      for (int g = 0; g < groups; g++)
        for (int h = 0; h < wpr; h++)
          for (int w = 0; w < wpr; w++)
            wq.push_back('{g*PC, 2*h, 2*w, (h == wpr-1) && (w == wpr-1),
                           (g == groups-1) && (h == wpr-1) && (w == wpr-1)});
    total = wq.size();
    idx = 0; cyc = 0; edges = 0;
    while (idx < total && cyc < 4000) begin
      @(negedge clk);
      check_eq({name, " inh"}, inh, wq[idx].h);
      check_eq({name, " inw"}, inw, wq[idx].w);
      check_eq({name, " sel"}, channel_sel, wq[idx].base);
      drive_block();
      case (enmode)
        0:       en = 1'b1;
        1:       en = (cyc % 2 == 0);
        default: en = ($urandom_range(0, 2) != 0);
      endcase
      @(posedge clk);
      #1;
      if (en) begin
        check_eq({name, " out_valid"}, out_valid, 1);
        check_eq({name, " channel_done"}, channel_done, wq[idx].glast);
        check_eq({name, " done"}, done, wq[idx].last);
        for (int c = 0; c < PC; c++) begin
          if (wq[idx].base + c < n) begin
            e = ref_pool(wq[idx].base + c, wq[idx].h, wq[idx].w);
            check_eq({name, " lane"}, lane_out(c), e);
            exp_last[c] = e;
            exp_ok[c]   = 1'b1;
          end else begin
            exp_ok[c] = 1'b0;
          end
        end
        idx++;
        edges++;
      end else begin
        check_eq({name, " idle out_valid"}, out_valid, 0);
        check_eq({name, " idle channel_done"}, channel_done, 0);
        check_eq({name, " idle done"}, done, 0);
        check_hold({name, " idle"});
      end
      cyc++;
    end
    check_eq({name, " enabled edges to done"}, edges,
             (s >= 2 && n > 0) ? wpr * wpr * groups : 0);
    exp_sel = (total > 0) ? (groups - 1) * PC : 0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive_block();
      en = 1'b1;
      @(posedge clk);
      #1;
      check_eq({name, " post done"}, done, 1);
      check_eq({name, " post out_valid"}, out_valid, 0);
      check_eq({name, " post channel_done"}, channel_done, 0);
      check_eq({name, " post inh"}, inh, 0);
      check_eq({name, " post inw"}, inw, 0);
      check_eq({name, " post sel"}, channel_sel, exp_sel);
      check_hold({name, " post"});
    end
    en = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    longint exp_signed;

    // Asynchronous reset in the middle of an enabled run, then idle.
    do_reset();
    in_size = 8'd16;
    channel_num = 8'd8;
    fill(0);
    repeat (10) begin
      @(negedge clk);
      drive_block();
      en = 1'b1;
    end
    @(negedge clk);
    drive_block();
    #2;
    rst = 1'b1;
    #1;
    check_zero_state("async rst");
    @(negedge clk);
    rst = 1'b0;
    en  = 1'b0;
    repeat (4) begin
      @(posedge clk);
      #1;
      check_zero_state("idle");
    end

    fill(0);
    run_case("rows full-en", 16, 8, 0);
    run_case("rows toggle-en", 16, 8, 1);
    fill(1);
    run_case("rand 16x8", 16, 8, 2);
    run_case("rand 5x6", 5, 6, 2);
    run_case("rand 7x3", 7, 3, 2);
    run_case("size1", 1, 8, 0);
    run_case("chan0", 8, 0, 2);

    // Signed corner: one all-negative window in every lane.
    do_reset();
    in_size = 8'd2;
    channel_num = 8'd4;
    for (int ch = 0; ch < PC; ch++) begin
      fm[ch][0][0] = -16'sd5;
      fm[ch][0][1] = -16'sd1;
      fm[ch][1][0] = -16'sd3;
      fm[ch][1][1] = -16'sd7;
    end
`ifdef POOL_AVG_EN
    exp_signed = -4;
`else
    exp_signed = -1;
`endif
    @(negedge clk);
    drive_block();
    en = 1'b1;
    @(posedge clk);
    #1;
    for (int c = 0; c < PC; c++) check_eq("signed lane", lane_out(c), exp_signed);
    check_eq("signed channel_done", channel_done, 1);
    check_eq("signed done", done, 1);
    en = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pool2x2_engine.md
Name: pool2x2_engine

Overview:
- 2x2, stride-2 pooling engine over a square feature map (in_size x in_size), PAR_CH channels in parallel.
- Generates window and channel addresses for an external feature buffer; the buffer returns the 2x2 block for those channels combinationally.
- Emits one pooled value per channel per enabled cycle.
- Sits between the feature memory and the next layer's input buffer.

Parameters:
- DATA_W, 16, element width (two's-complement signed).
- PAR_CH, 4, channels processed per cycle.
- CNT_W, 8, width of size, channel-count and address counters.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- en  in  1  advance enable; low = pause, all state held
- in_size  in  CNT_W  feature map height = width; stable while running
- channel_num  in  CNT_W  total channels; stable while running
- infeature_block  in  PAR_CH*4*DATA_W  element at lane c, row r, col k is at bits [DATA_W*(c*4+r*2+k) +: DATA_W]; row r = inh+r, col k = inw+k, channel channel_sel+c
- outfeature  out  PAR_CH*DATA_W  pooled result; lane c at [DATA_W*c +: DATA_W]
- inh  out  CNT_W  top row of current window
- inw  out  CNT_W  left column of current window
- channel_sel  out  CNT_W  base channel of current group
- channel_done  out  1  one-cycle pulse with last output of a channel group
- done  out  1  sticky: all groups finished
- out_valid  out  1  outfeature updated on this clock edge

Behaviour:
- Reset (async): inh = 0, inw = 0, channel_sel = 0, outfeature = 0, out_valid = 0, channel_done = 0, done = 0.
- Addresses are registered and drive the buffer directly; infeature_block is consumed in the same cycle.
- On each rising edge with en = 1 and done = 0:
  - outfeature lane c <= max of the 4 signed elements of lane c.
  - out_valid <= 1.
  - Counters advance.
- Otherwise out_valid <= 0 and channel_done <= 0; outfeature holds.
- Latency: the result for the address presented in cycle n is visible after edge n.
- Counter sequence:
  - inw += 2.
  - If inw + 2 > in_size - 2: inw <= 0, inh += 2.
  - If inh also wraps (inh + 2 > in_size - 2): inh <= 0, channel_sel += PAR_CH, and channel_done pulses with that last output.
  - If channel_sel + PAR_CH >= channel_num at that wrap: done <= 1 and channel_sel holds.
- Odd in_size: the last row and column are ignored (floor).
- in_size < 2 or channel_num = 0: the first enabled edge sets done = 1 with out_valid = 0.
- channel_num not a multiple of PAR_CH: the last group still runs; out-of-range lanes are don't-care.
- done is cleared only by rst; while done = 1, en is ignored and counters hold.
- Windows per group = (in_size/2)^2. Enabled cycles to done = that value times ceil(channel_num/PAR_CH).

Optional Feature:
- Macro POOL_AVG_EN.
- Defined: each lane outputs (sum of 4 sign-extended values, DATA_W+2 bits) arithmetic-shifted right by 2, truncated to DATA_W. This is average pooling.
- Undefined: max pooling as above.
- Sequencing and timing are identical in both modes.

Decomposition:
- Shared package pool_pkg holds DATA_W, PAR_CH, CNT_W defaults and a lane-slice index helper.
- One sub-module, pool_reduce4: combinational 4-input signed max (or average under POOL_AVG_EN), instantiated PAR_CH times.
- The top level holds the counters, flags and output registers.

Test Plan:
- Reset and idle: assert rst mid-run with en = 1 -> all outputs 0 immediately; hold en = 0 -> addresses stay 0, out_valid = 0.
- Row pattern: in_size = 16, channel_num = 8, element = (row%3)+1.
  - Window rows 0-1 -> all lanes 2; rows 2-3 -> 3; rows 4-5 -> 3; rows 6-7 -> 2.
  - inw steps 0, 2, ..., 14, then inh steps by 2.
- Group and done timing, same setup:
  - channel_done pulses after enabled edges 64 and 128.
  - channel_sel goes 0 -> 4.
  - done rises at edge 128 and stays high with en still high.
- Pause: toggle en every other cycle -> addresses and outfeature freeze on low cycles; total enabled edges to done is still 128.
- Signed and edge cases:
  - Block {-5, -1, -3, -7} -> max -1 (avg -4 under POOL_AVG_EN).
  - in_size = 5 -> 4 windows per group.
  - channel_num = 6 -> 2 groups.
  - in_size = 1 -> done after the first enabled edge.
